// File: rtl/expr_lane_pipe_if.sv
// Stream bundle for expr_lane_pipe: operand input stream, result output stream
// and the saturating zero-divisor count.
interface expr_lane_pipe_if #(
    parameter int WIDTH = 6,
    parameter int LANES = 4,
    parameter int CNT_W = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             in_op;
    logic [LANES-1:0]       in_sgn;
    logic [LANES*WIDTH-1:0] in_a;
    logic [LANES*WIDTH-1:0] in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_y;
    logic [LANES-1:0]       out_dz;
    logic [CNT_W-1:0]       dz_cnt;

    modport master (
        output in_valid, in_op, in_sgn, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y, out_dz, dz_cnt
    );

    modport slave (
        input  in_valid, in_op, in_sgn, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y, out_dz, dz_cnt
    );
endinterface

// File: rtl/expr_lane_pipe.sv
// Multi-lane opcode evaluator: combinational lane ALUs feeding a PIPE-deep
// valid/ready register chain, plus a saturating count of zero-divisor lanes.
module expr_lane_pipe #(
    parameter int WIDTH = 6,
    parameter int LANES = 4,
    parameter int PIPE  = 2,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic reset,
    expr_lane_pipe_if.slave bus
);
    localparam int DW = LANES * WIDTH;

    logic [DW-1:0]    res_y;
    logic [LANES-1:0] res_dz;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] a_l, b_l, y_l;
        logic [WIDTH:0]   a_mag, b_mag, r_mag;
        logic             sgn_l, a_neg, b_neg, b_big, lt, dz_l;

        assign a_l   = bus.in_a[(LANES-1-gi)*WIDTH +: WIDTH];
        assign b_l   = bus.in_b[(LANES-1-gi)*WIDTH +: WIDTH];
        assign sgn_l = bus.in_sgn[gi];
        assign a_neg = sgn_l & a_l[WIDTH-1];
        assign b_neg = sgn_l & b_l[WIDTH-1];
        // One extra bit so the most-negative value has a representable magnitude.
        assign a_mag = a_neg ? -{1'b1, a_l} : {1'b0, a_l};
        assign b_mag = b_neg ? -{1'b1, b_l} : {1'b0, b_l};
        assign b_big = 33'(b_l) >= 33'(WIDTH);
        assign lt    = sgn_l ? ($signed(a_l) < $signed(b_l)) : (a_l < b_l);

        always_comb begin
            y_l   = '0;
            dz_l  = 1'b0;
            r_mag = '0;
            case (bus.in_op)
                3'd0: y_l = a_l + b_l;
                3'd1: y_l = a_l - b_l;
                3'd2: y_l = ~(a_l ^ b_l);
                3'd3: y_l = b_big ? '0 : (a_l << b_l);
                3'd4: begin
                    if (sgn_l)
                        y_l = b_big ? {WIDTH{a_l[WIDTH-1]}} : $unsigned($signed(a_l) >>> b_l);
                    else
                        y_l = b_big ? '0 : (a_l >> b_l);
                end
                3'd5: y_l = {{(WIDTH-1){1'b0}}, lt};
                3'd6: begin
                    if (b_l == '0) begin
                        dz_l = 1'b1;
                    end else begin
                        // Remainder sign follows the dividend.
                        r_mag = a_mag % b_mag;
                        y_l   = a_neg ? WIDTH'(-r_mag) : r_mag[WIDTH-1:0];
                    end
                end
                default: y_l = {{(WIDTH-1){1'b0}}, ~^(a_l & b_l)};
            endcase
        end

        assign res_y[(LANES-1-gi)*WIDTH +: WIDTH] = y_l;
        assign res_dz[gi]                         = dz_l;
    end

    logic [PIPE-1:0]              valid_q, valid_d, load;
    logic [PIPE-1:0][DW-1:0]      y_q, y_d;
    logic [PIPE-1:0][LANES-1:0]   dz_q, dz_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [CNT_W+4:0]             cnt_sum;
    logic                         ld_chain;

    always_comb begin
        // A stage may load if it or any stage downstream of it is empty.
        ld_chain = bus.out_ready;
        load     = '0;
        for (int k = PIPE - 1; k >= 0; k--) begin
            ld_chain = ld_chain || !valid_q[k];
            load[k]  = ld_chain;
        end

        valid_d = valid_q;
        y_d     = y_q;
        dz_d    = dz_q;
        if (load[0]) begin
            valid_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                y_d[0]  = res_y;
                dz_d[0] = res_dz;
            end
        end
        for (int k = 1; k < PIPE; k++) begin
            if (load[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    y_d[k]  = y_q[k-1];
                    dz_d[k] = dz_q[k-1];
                end
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        cnt_sum = (CNT_W+5)'(cnt_q) + (CNT_W+5)'($countones(dz_q[PIPE-1]));
        if (valid_q[PIPE-1] && bus.out_ready) begin
            if (cnt_sum > (CNT_W+5)'({CNT_W{1'b1}}))
                cnt_d = '1;
            else
                cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            y_q     <= '0;
            dz_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = valid_q[PIPE-1];
    assign bus.out_y     = y_q[PIPE-1];
    assign bus.out_dz    = dz_q[PIPE-1];
    assign bus.dz_cnt    = cnt_q;
endmodule

// File: tb/tb_expr_lane_pipe.sv
// Directed plus randomized bench for expr_lane_pipe with an arithmetic
// reference model and an in-order scoreboard.
module tb_expr_lane_pipe;
    localparam int W    = 6;
    localparam int L    = 4;
    localparam int P    = 2;
    localparam int C    = 8;
    localparam int CMAX = (1 << C) - 1;

    typedef struct {
        logic [L*W-1:0] y;
        logic [L-1:0]   dz;
    } exp_t;

    logic clk, reset;
    expr_lane_pipe_if #(.WIDTH(W), .LANES(L), .CNT_W(C)) bus ();

    expr_lane_pipe #(.WIDTH(W), .LANES(L), .PIPE(P), .CNT_W(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             n_chk = 0, n_pass = 0, n_emit = 0, cnt_m = 0;
    exp_t           q[$];
    bit             acc, stall_prev;
    logic [L*W-1:0] held_y, last_y;
    logic [L-1:0]   held_dz, last_dz;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [L*W-1:0] pack4(int l0, int l1, int l2, int l3);
        int             v[4];
        logic [L*W-1:0] r;
        v = '{l0, l1, l2, l3};
        r = '0;
        for (int i = 0; i < L; i++) r[(L-1-i)*W +: W] = W'(v[i]);
        return r;
    endfunction

    function automatic int lane_of(logic [L*W-1:0] y, int i);
        return int'(y[(L-1-i)*W +: W]);
    endfunction

    // Reference: operands converted to plain integers, evaluated arithmetically.
    function automatic exp_t model_txn(logic [2:0] op, logic [L-1:0] sgn,
                                       logic [L*W-1:0] a, logic [L*W-1:0] b);
        exp_t e;
        int   ua, ub, sa, sb, r;
        bit   s;
        e.y  = '0;
        e.dz = '0;
        for (int i = 0; i < L; i++) begin
            ua = lane_of(a, i);
            ub = lane_of(b, i);
            s  = sgn[i];
            sa = (s && ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
            sb = (s && ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
            r  = 0;
            case (op)
                3'd0: r = ua + ub;
                3'd1: r = ua - ub;
                3'd2: r = ~(ua ^ ub);
                3'd3: r = (ub >= W) ? 0 : (ua << ub);
                3'd4: if (s) r = (ub >= W) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
                      else   r = (ub >= W) ? 0 : (ua >> ub);
                3'd5: r = s ? int'(sa < sb) : int'(ua < ub);
                3'd6: if (ub == 0) e.dz[i] = 1'b1;
                      else r = s ? (sa % sb) : (ua % ub);
                default: r = ($countones(ua & ub) % 2 == 0) ? 1 : 0;
            endcase
            e.y[(L-1-i)*W +: W] = W'(r);
        end
        return e;
    endfunction

    task automatic cyc();
        exp_t e;
        #2;
        if (stall_prev) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_y", 64'(bus.out_y), 64'(held_y));
            check("hold_dz", 64'(bus.out_dz), 64'(held_dz));
        end
        acc = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
            check("spurious_out", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("out_y", 64'(bus.out_y), 64'(e.y));
                check("out_dz", 64'(bus.out_dz), 64'(e.dz));
                last_y  = bus.out_y;
                last_dz = bus.out_dz;
                n_emit++;
                cnt_m = cnt_m + $countones(e.dz);
                if (cnt_m > CMAX) cnt_m = CMAX;
            end
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        held_y     = bus.out_y;
        held_dz    = bus.out_dz;
        if (bus.in_valid && bus.in_ready) begin
            q.push_back(model_txn(bus.in_op, bus.in_sgn, bus.in_a, bus.in_b));
            acc = 1'b1;
        end
        @(negedge clk);
        $display("cycle t=%0t in_acc=%0d out_v=%0d out_y=%h dz=%b dz_cnt=%0d",
                 $time, acc, bus.out_valid, bus.out_y, bus.out_dz, bus.dz_cnt);
        check("dz_cnt", 64'(bus.dz_cnt), 64'(cnt_m));
    endtask

    task automatic send(logic [2:0] op, logic [L-1:0] sgn, logic [L*W-1:0] a, logic [L*W-1:0] b);
        bus.in_op    = op;
        bus.in_sgn   = sgn;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) cyc();
        check("send_timeout", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() > 0; i++) cyc();
        check("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset      = 1'b0;
        q.delete();
        cnt_m      = 0;
        stall_prev = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_y", 64'(bus.out_y), 64'd0);
        check("rst_out_dz", 64'(bus.out_dz), 64'd0);
        check("rst_dz_cnt", 64'(bus.dz_cnt), 64'd0);
    endtask

    initial begin
        int emit0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_sgn    = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        stall_prev    = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Reset mid-stream: two held ops (one with zero divisors) must vanish.
        bus.out_ready = 1'b0;
        send(3'd6, 4'hF, pack4(5, 5, 5, 5), pack4(0, 0, 0, 0));
        send(3'd0, 4'h0, pack4(1, 2, 3, 4), pack4(1, 1, 1, 1));
        do_reset();
        bus.out_ready = 1'b1;
        repeat (6) cyc();
        check("flushed_no_emit", 64'(n_emit), 64'd0);

        // ADD wrap with latency check, then signed SUB wrap.
        send(3'd0, 4'h0, pack4(63, 0, 0, 0), pack4(1, 0, 0, 0));
        for (int k = 1; k < P; k++) begin
            #1 check("lat_early", 64'(bus.out_valid), 64'd0);
            cyc();
        end
        #1 check("lat_at_pipe", 64'(bus.out_valid), 64'd1);
        drain();
        check("add_wrap", 64'(lane_of(last_y, 0)), 64'd0);
        send(3'd1, 4'b0010, pack4(0, -32, 0, 0), pack4(0, 1, 0, 0));
        drain();
        check("sub_wrap", 64'(lane_of(last_y, 1)), 64'h1F);

        // Shift bounds.
        send(3'd4, 4'b0001, pack4(-20, -20, 0, 0), pack4(7, 7, 0, 0));
        drain();
        check("shr_signed_big", 64'(lane_of(last_y, 0)), 64'h3F);
        check("shr_unsigned_big", 64'(lane_of(last_y, 1)), 64'h00);
        send(3'd3, 4'b0000, pack4(1, 0, 0, 0), pack4(5, 0, 0, 0));
        drain();
        check("shl_5", 64'(lane_of(last_y, 0)), 64'h20);

        // Remainder corners from a cleared counter.
        do_reset();
        send(3'd6, 4'hF, pack4(-7, -32, 5, 5), pack4(3, -1, 0, 0));
        drain();
        check("mod_neg", 64'(lane_of(last_y, 0)), 64'h3F);
        check("mod_minneg_m1", 64'(lane_of(last_y, 1)), 64'h00);
        check("mod_by_zero", 64'(lane_of(last_y, 2)), 64'h00);
        check("mod_dz_flags", 64'(last_dz), 64'b1100);
        check("dz_cnt_after_mod", 64'(bus.dz_cnt), 64'd2);

        // LT signedness and RXN parity.
        send(3'd5, 4'b0001, pack4(-1, 63, 0, 0), pack4(0, 0, 0, 0));
        drain();
        check("lt_signed", 64'(lane_of(last_y, 0)), 64'd1);
        check("lt_unsigned", 64'(lane_of(last_y, 1)), 64'd0);
        send(3'd7, 4'b0000, pack4(63, 0, 0, 0), pack4(63, 0, 0, 0));
        drain();
        check("rxn_even", 64'(lane_of(last_y, 0)), 64'd1);

        // Backpressure: five ops against a stalled output.
        emit0 = n_emit;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++)
            send(3'($urandom_range(0, 7)), 4'($urandom), 24'($urandom), 24'($urandom));
        bus.in_op    = 3'($urandom_range(0, 7));
        bus.in_sgn   = 4'($urandom);
        bus.in_a     = 24'($urandom);
        bus.in_b     = 24'($urandom);
        bus.in_valid = 1'b1;
        repeat (3) begin
            #1 check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            cyc();
        end
        bus.out_ready = 1'b1;
        send(bus.in_op, bus.in_sgn, bus.in_a, bus.in_b);
        for (int i = 3; i < 5; i++)
            send(3'($urandom_range(0, 7)), 4'($urandom), 24'($urandom), 24'($urandom));
        drain();
        check("bp_emit_count", 64'(n_emit - emit0), 64'd5);

        // Randomized traffic with random backpressure and frequent zero divisors.
        for (int i = 0; i < 400; i++) begin
            logic [L*W-1:0] b;
            b = 24'($urandom);
            for (int j = 0; j < L; j++)
                if ($urandom_range(0, 4) == 0) b[j*W +: W] = '0;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_op     = 3'($urandom_range(0, 7));
            bus.in_sgn    = 4'($urandom);
            bus.in_a      = 24'($urandom);
            bus.in_b      = b;
            cyc();
        end
        bus.in_valid = 1'b0;
        drain();

        // Saturation: 70 ops with four zero-divisor lanes each.
        do_reset();
        for (int i = 0; i < 70; i++)
            send(3'd6, 4'($urandom), 24'($urandom), 24'd0);
        drain();
        check("dz_cnt_saturated", 64'(bus.dz_cnt), 64'd255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/expr_lane_pipe.md
Name: expr_lane_pipe

Overview:
- Parametrised, pipelined successor to the flat random-expression blocks used in regression.
- Evaluates one opcode per lane across LANES independent operand pairs of WIDTH bits each. Each lane has its own signedness select.
- Results leave on a valid/ready stream, packed lane 0 at the MSBs (same concatenation order as the combinational expression modules).
- Also counts divide-by-zero events for regression self-checking.

Parameters:
WIDTH, 6, operand/result width per lane (2..32)
LANES, 4, number of parallel lanes (1..16)
PIPE, 2, pipeline register stages, input to output (1..4)
CNT_W, 8, width of the saturating zero-divisor counter

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  transaction offered
in_ready  out  1  transaction accepted when in_valid&&in_ready
in_op  in  3  opcode applied to all lanes
in_sgn  in  LANES  per-lane signed mode (bit i = lane i)
in_a  in  LANES*WIDTH  operand A, lane 0 at MSBs
in_b  in  LANES*WIDTH  operand B, lane 0 at MSBs
out_valid  out  1  result available
out_ready  in  1  consumer accepts when out_valid&&out_ready
out_y  out  LANES*WIDTH  results, lane 0 at MSBs
out_dz  out  LANES  per-lane divisor-was-zero flag for this result
dz_cnt  out  CNT_W  saturating count of lane-level zero-divisor events

Behaviour:
- Reset value: clk and reset fixed as stated (single clock; reset synchronous, active-high). All stage valid bits 0; out_valid=0, out_y=0, out_dz=0, dz_cnt=0. A reset asserted mid-operation drops every in-flight transaction, with no output.
- Opcodes. "s" means lane signed (in_sgn[i]=1). Operands are interpreted as signed two's complement or unsigned per lane.
  - 0 ADD: a+b mod 2^WIDTH.
  - 1 SUB: a-b mod 2^WIDTH.
  - 2 XNOR: ~(a^b).
  - 3 SHL: a<<b. b is taken as unsigned full width; if b>=WIDTH, result is 0.
  - 4 SHR:
    - s: arithmetic shift; if b>=WIDTH, result is all copies of a's MSB.
    - unsigned: logical shift; if b>=WIDTH, result is 0.
  - 5 LT: a<b under lane signedness; result is zero-extended 1/0.
  - 6 MOD: a%b, with the sign of the result following a in signed mode.
    - b==0: result 0 and out_dz[i]=1.
    - Signed most-negative % -1: result 0.
  - 7 RXN: reduction XNOR of (a&b), zero-extended.
- Computation: fully combinational before the first register. Stages 2..PIPE only carry data forward.
- Latency: with out_ready held high, a result appears PIPE cycles after acceptance. Throughput is 1 per cycle.
- Handshake:
  - Each stage k holds valid_k. Stage k loads when !valid_k || (stage k+1 loads). The last stage loads when !out_valid || out_ready.
  - in_ready = stage-0 load condition. It is combinational from out_ready, and there is no combinational in->out data path.
  - Bubbles collapse: a stalled output does not block upstream stages that are empty.
  - out_y, out_valid and out_dz stay stable while out_valid && !out_ready.
  - in_* are ignored when !in_valid or !in_ready.
- dz_cnt:
  - Increments by popcount(out_dz) on each output handshake, not at acceptance, so flushed transactions are not counted.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- Simultaneous accept and emit in the same cycle is legal with a full pipeline: everything shifts.

Test Plan:
- Reset mid-stream: PIPE=2; accept 2 ops; assert reset 1 cycle -> out_valid=0 next cycle, the ops are never emitted, dz_cnt=0.
- ADD/SUB wrap: WIDTH=6, lane0 unsigned a=63 b=1 ADD -> 0; lane1 signed a=-32 b=1 SUB -> 31. out_y appears exactly 2 cycles after accept with out_ready=1.
- Shift bounds: WIDTH=6.
  - Signed a=-20 (0x2C), b=7, SHR -> 0x3F.
  - Unsigned same operands SHR -> 0.
  - SHL with b=5, a=1 -> 0x20.
- MOD corner cases, WIDTH=6, signed:
  - -7%3 -> -1.
  - -32%-1 -> 0.
  - 5%0 -> 0 with out_dz bit set.
  - After the emit handshake, dz_cnt increases by the number of zero-divisor lanes.
  - With CNT_W=2, repeated zero-divisor results saturate dz_cnt at 3.
- Backpressure: hold out_ready=0 with a stream of 5 ops -> in_ready drops after PIPE accepts and out_y is held constant. Release out_ready -> all 5 results emerge in order, no loss or duplication.
- LT/RXN signedness: lane signed a=-1 b=0 LT -> 1; unsigned a=63 b=0 LT -> 0. RXN with a=0x3F b=0x3F on WIDTH=6 -> 1 (even popcount).
